ctr_mode_sched: RTL

- Sequences and shares one 4-bit shift counter (Johnson/ring, select line `c`, reset `rstn`) between two requesters.
- Requester 0 wants mode sel=0; requester 1 wants mode sel=1.
- Per grant: holds counter in reset, sets mode, runs it a fixed burst, captures its final value, then idles a gap.
- Sits between the counter instance and client logic; replaces hand-sequenced stimulus of the counter's select/reset.

---
 rtl/ctr_mode_sched_pkg.sv | 29 ++
 rtl/ctr_rr_arb.sv | 19 +
 rtl/ctr_mode_sched.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ctr_mode_sched_pkg.sv
// Shared types and defaults for the shift-counter mode scheduler.
// The state enum, parameter defaults, requester indices and counter width helper live here.
package ctr_mode_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RESET = 2'd1,
        RUN   = 2'd2,
        GAP   = 2'd3
    } state_e;

    localparam int DEF_W          = 4;
    localparam int DEF_RST_CYCLES = 2;
    localparam int DEF_BURST_LEN  = 15;
    localparam int DEF_GAP_CYCLES = 5;

    localparam logic REQ_JOHNSON = 1'b0;
    localparam logic REQ_RING    = 1'b1;

    // One down-counter serves every timed state, so size it for the longest one.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ctr_rr_arb.sv
// Two-way round-robin pick. The pointer names the preferred requester,
// and the other requester is chosen only when the preferred one is not requesting.
module ctr_rr_arb (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] pick,
    output logic       idx,
    output logic       valid
);

    always_comb begin
        idx   = ptr;
        pick  = 2'b00;
        valid = |req;
        if (!req[ptr]) idx = ~ptr;
        if (req[idx]) pick = (idx == 1'b1) ? 2'b10 : 2'b01;
    end

endmodule

// File: rtl/ctr_mode_sched.sv
// Shares one shift counter between two requesters. Each grant holds the counter in reset,
// sets its mode, runs a fixed burst, captures the final value, then idles for a gap.
module ctr_mode_sched
    import ctr_mode_sched_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int BURST_LEN  = DEF_BURST_LEN,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [1:0]   req,
    input  logic [W-1:0] ctr_out,
    output logic         ctr_rstn,
    output logic         ctr_sel,
    output logic [1:0]   gnt,
    output logic         busy,
    output logic [1:0]   done,
    output logic [1:0]   abort,
    output logic [W-1:0] last_out
);

    localparam int CW = cnt_width(RST_CYCLES, BURST_LEN, GAP_CYCLES);

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [1:0]     gnt_q, gnt_d;
    logic           ctr_rstn_q, ctr_rstn_d;
    logic           ctr_sel_q, ctr_sel_d;
    logic           busy_q, busy_d;
    logic [1:0]     done_q, done_d;
    logic [1:0]     abort_q, abort_d;
    logic [W-1:0]   last_out_q, last_out_d;
    logic           ptr_q, ptr_d;

    logic [1:0]     arb_pick;
    logic           arb_idx;
    logic           arb_valid;

    ctr_rr_arb u_arb (
        .req   (req),
        .ptr   (ptr_q),
        .pick  (arb_pick),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // ctr_sel doubles as the owner index while a grant is active.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        ctr_rstn_d = ctr_rstn_q;
        ctr_sel_d  = ctr_sel_q;
        done_d     = 2'b00;
        abort_d    = 2'b00;
        last_out_d = last_out_q;
        ptr_d      = ptr_q;

        case (state_q)
            IDLE: begin
                ctr_rstn_d = 1'b0;
                if (arb_valid) begin
                    state_d   = RESET;
                    gnt_d     = arb_pick;
                    ctr_sel_d = arb_idx;
                    cnt_d     = CW'(RST_CYCLES - 1);
                end
            end
            RESET, RUN: begin
                if (!req[ctr_sel_q]) begin
                    state_d             = GAP;
                    abort_d[ctr_sel_q]  = 1'b1;
                    gnt_d               = 2'b00;
                    ctr_rstn_d          = 1'b0;
                    ptr_d               = ~ctr_sel_q;
                    cnt_d               = CW'(GAP_CYCLES - 1);
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (state_q == RESET) begin
                    state_d    = RUN;
                    ctr_rstn_d = 1'b1;
                    cnt_d      = CW'(BURST_LEN - 1);
                end else begin
                    state_d            = GAP;
                    last_out_d         = ctr_out;
                    done_d[ctr_sel_q]  = 1'b1;
                    gnt_d              = 2'b00;
                    ctr_rstn_d         = 1'b0;
                    ptr_d              = ~ctr_sel_q;
                    cnt_d              = CW'(GAP_CYCLES - 1);
                end
            end
            GAP: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                else state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            gnt_q      <= 2'b00;
            ctr_rstn_q <= 1'b0;
            ctr_sel_q  <= REQ_JOHNSON;
            busy_q     <= 1'b0;
            done_q     <= 2'b00;
            abort_q    <= 2'b00;
            last_out_q <= '0;
            ptr_q      <= REQ_JOHNSON;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            ctr_rstn_q <= ctr_rstn_d;
            ctr_sel_q  <= ctr_sel_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            last_out_q <= last_out_d;
            ptr_q      <= ptr_d;
        end
    end

    assign ctr_rstn = ctr_rstn_q;
    assign ctr_sel  = ctr_sel_q;
    assign gnt      = gnt_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign abort    = abort_q;
    assign last_out = last_out_q;

endmodule
